// File: rtl/light_switch_ctrl.sv
// Main lamp controller: debounces the push-button, lights the lamp on a press or on presence,
// and turns it off on a press or on the auto-shutdown pulse C, with a post-manual-off hold-off.
module light_switch_ctrl #(
   parameter int DEBOUNCE_T = 50,
   parameter int HOLDOFF_T  = 10000,
   parameter bit AUTO_ON    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic infravermelho,
   input  logic C,
   output logic lamp,
   output logic timer_enable,
   output logic manual_off
);

   localparam int DW = $clog2(DEBOUNCE_T + 1);
   localparam int HW = $clog2(HOLDOFF_T + 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_T);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_T - 1);

   typedef enum logic [1:0] {
      P_IDLE       = 2'd0,
      P_DEBOUNCING = 2'd1,
      P_HELD       = 2'd2
   } press_state_e;

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_ON      = 2'd1,
      S_HOLDOFF = 2'd2
   } main_state_e;

   press_state_e    pst_q;
   logic [DW-1:0]   deb_cnt_q;
   logic            press_q;

   main_state_e     st_q, st_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            lamp_q;
   logic            manual_off_q;

   // Press qualifier: one press per debounced high run; press_q is a single-cycle strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pst_q     <= P_IDLE;
         deb_cnt_q <= '0;
         press_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here; the later assignment in a branch overrides this default.
         press_q <= 1'b0;
         case (pst_q)
            P_IDLE: begin
               if (btn) begin
                  deb_cnt_q <= DEB_ONE;
                  if (DEB_ONE == DEB_LAST) begin
                     press_q <= 1'b1;
                     pst_q   <= P_HELD;
                  end else begin
                     pst_q   <= P_DEBOUNCING;
                  end
               end
            end
            P_DEBOUNCING: begin
               if (!btn) begin
                  pst_q     <= P_IDLE;
                  deb_cnt_q <= '0;
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_ONE;
                  if (deb_cnt_q + DEB_ONE == DEB_LAST) begin
                     press_q <= 1'b1;
                     pst_q   <= P_HELD;
                  end
               end
            end
            P_HELD: begin
               if (!btn) begin
                  pst_q     <= P_IDLE;
                  deb_cnt_q <= '0;
               end
            end
            default: begin
               pst_q     <= P_IDLE;
               deb_cnt_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      st_d       = st_q;
      hold_cnt_d = hold_cnt_q;
      case (st_q)
         S_OFF: begin
            hold_cnt_d = '0;
            if (press_q || (AUTO_ON && infravermelho)) st_d = S_ON;
         end
         S_ON: begin
            if (press_q) begin
               st_d       = S_HOLDOFF;
               hold_cnt_d = '0;
            end else if (C) begin
               st_d       = S_OFF;
            end
         end
         S_HOLDOFF: begin
            if (press_q) begin
               st_d       = S_ON;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               st_d       = S_OFF;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
         default: begin
            st_d       = S_OFF;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they track the state with no extra latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= S_OFF;
         hold_cnt_q   <= '0;
         lamp_q       <= 1'b0;
         manual_off_q <= 1'b0;
      end else begin
         st_q         <= st_d;
         hold_cnt_q   <= hold_cnt_d;
         lamp_q       <= (st_d == S_ON);
         manual_off_q <= (st_d == S_HOLDOFF);
      end
   end

   assign lamp         = lamp_q;
   assign timer_enable = lamp_q;
   assign manual_off   = manual_off_q;

endmodule

// File: tb/tb_light_switch_ctrl.sv
// Bench for light_switch_ctrl: two instances (AUTO_ON=1 and AUTO_ON=0) share stimulus and are
// compared every cycle against a run-length/countdown model, plus directed literal checks.
module tb_light_switch_ctrl;

   localparam int DT = 4;
   localparam int HT = 8;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic btn  = 1'b0;
   logic ir   = 1'b0;
   logic c_in = 1'b0;
   logic lamp1, te1, mo1;
   logic lamp0, te0, mo0;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   light_switch_ctrl #(.DEBOUNCE_T(DT), .HOLDOFF_T(HT), .AUTO_ON(1'b1)) dut (
      .clk(clk), .rst(rst), .btn(btn), .infravermelho(ir), .C(c_in),
      .lamp(lamp1), .timer_enable(te1), .manual_off(mo1));

   light_switch_ctrl #(.DEBOUNCE_T(DT), .HOLDOFF_T(HT), .AUTO_ON(1'b0)) dut_noauto (
      .clk(clk), .rst(rst), .btn(btn), .infravermelho(ir), .C(c_in),
      .lamp(lamp0), .timer_enable(te0), .manual_off(mo0));

   task automatic check(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a press is the edge at which the current high run of btn reaches DT samples; it takes
   // effect one edge later. Index 1 models AUTO_ON=1, index 0 models AUTO_ON=0.
   int run_len    = 0;
   bit press_pipe = 1'b0;
   bit m_on[2]    = '{1'b0, 1'b0};
   int m_hold[2]  = '{0, 0};

   always @(posedge clk or posedge rst) begin : model
      bit act;
      if (rst) begin
         run_len    = 0;
         press_pipe = 1'b0;
         m_on       = '{1'b0, 1'b0};
         m_hold     = '{0, 0};
      end else begin
         act = press_pipe;
         if (btn) run_len = run_len + 1;
         else     run_len = 0;
         press_pipe = btn && (run_len == DT);
         for (int a = 0; a < 2; a++) begin
            if (m_hold[a] > 0) begin
               if (act) begin m_on[a] = 1'b1; m_hold[a] = 0; end
               else m_hold[a] = m_hold[a] - 1;
            end else if (m_on[a]) begin
               if (act) begin m_on[a] = 1'b0; m_hold[a] = HT; end
               else if (c_in) m_on[a] = 1'b0;
            end else if (act || (ir && a == 1)) begin
               m_on[a] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("lamp_auto",     lamp1, m_on[1]);
      check("te_auto",       te1,   m_on[1]);
      check("holdoff_auto",  mo1,   m_hold[1] > 0);
      check("lamp_noauto",   lamp0, m_on[0]);
      check("te_noauto",     te0,   m_on[0]);
      check("holdoff_noauto", mo0,  m_hold[0] > 0);
   end

   // Called at a negedge: holds the inputs for n rising edges, returns at the negedge after them.
   task automatic apply(input logic b, input logic i, input logic c, input int n);
      btn = b; ir = i; c_in = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset(input string nm);
      #2 rst = 1'b1;
      #1;
      check({nm, "_lamp"},   lamp1, 1'b0);
      check({nm, "_te"},     te1,   1'b0);
      check({nm, "_mo"},     mo1,   1'b0);
      check({nm, "_lamp0"},  lamp0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_lamp", lamp1, 1'b0);
      check("reset_te",   te1,   1'b0);
      check("reset_mo",   mo1,   1'b0);

      // Debounced press: lamp rises at edge DT+1, no toggle while held.
      apply(1, 0, 0, 4);
      check("press_not_yet", lamp1, 1'b0);
      apply(1, 0, 0, 1);
      check("press_on",      lamp1, 1'b1);
      check("press_on_te",   te1,   1'b1);
      check("press_on_noauto", lamp0, 1'b1);
      apply(1, 0, 0, 20);
      check("held_no_toggle", lamp1, 1'b1);
      apply(0, 0, 0, 2);

      // Timer pulse turns the lamp off; a second pulse in OFF does nothing.
      apply(0, 0, 1, 1);
      check("c_off_lamp", lamp1, 1'b0);
      check("c_off_te",   te1,   1'b0);
      apply(0, 0, 1, 1);
      check("c_in_off",   lamp1, 1'b0);
      apply(0, 0, 0, 1);

      // Short presses never qualify.
      repeat (5) begin
         apply(1, 0, 0, 3);
         apply(0, 0, 0, 1);
      end
      check("short_press", lamp1, 1'b0);

      // Manual off with presence held: HT cycles of HOLDOFF, one OFF cycle, then relit.
      apply(1, 0, 0, 5);
      apply(0, 0, 0, 1);
      check("ho_pre_on", lamp1, 1'b1);
      apply(1, 1, 0, 4);
      apply(1, 1, 0, 1);
      check("ho_enter_mo",   mo1,   1'b1);
      check("ho_enter_lamp", lamp1, 1'b0);
      apply(0, 1, 0, 7);
      check("ho_last_mo",    mo1,   1'b1);
      apply(0, 1, 0, 1);
      check("ho_exit_mo",    mo1,   1'b0);
      check("ho_exit_lamp",  lamp1, 1'b0);
      apply(0, 1, 0, 1);
      check("ho_relit",      lamp1, 1'b1);
      check("ho_noauto_off", lamp0, 1'b0);

      // Press and C on the same edge: press wins.
      apply(1, 1, 0, 4);
      apply(1, 1, 1, 1);
      check("press_beats_c", mo1, 1'b1);
      apply(0, 0, 0, HT + 2);
      apply(0, 0, 1, 1);
      check("noauto_c_off", lamp0, 1'b0);
      apply(0, 1, 0, 100);
      check("noauto_ir_stays_off", lamp0, 1'b0);
      check("auto_ir_on",          lamp1, 1'b1);

      // Reset mid-debounce (counter=2): needs the full DT fresh samples afterwards.
      apply(1, 0, 0, 2);
      pulse_reset("rst_deb");
      apply(1, 0, 0, 4);
      check("rst_deb_not_yet", lamp1, 1'b0);
      apply(1, 0, 0, 1);
      check("rst_deb_on",      lamp1, 1'b1);
      apply(0, 0, 0, 1);

      // Reset mid-holdoff (counter=5).
      apply(1, 0, 0, 5);
      apply(0, 0, 0, 5);
      check("rst_ho_in", mo1, 1'b1);
      pulse_reset("rst_ho");
      apply(1, 0, 0, 4);
      check("rst_ho_not_yet", lamp1, 1'b0);
      apply(1, 0, 0, 1);
      check("rst_ho_on",      lamp1, 1'b1);
      apply(0, 0, 0, 1);

      // Randomised traffic, checked every cycle by the compare process.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 5) == 0) btn = ~btn;
         ir   = ($urandom_range(0, 3) == 0);
         c_in = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 599) == 0) pulse_reset("rand_rst");
         else @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
